pipelined_carry_adder: RTL and testbench

- Parametrised, pipelined successor to the team's combinational ripple-carry adder.
- Splits an N-bit add/subtract into STAGES equal chunks.
- Each chunk is added in its own pipeline stage, and the carry is registered between stages.
- Sits on datapaths that need more than N≈16 bits at full clock rate, behind a valid/ready stream interface with backpressure.

---
 rtl/pipelined_carry_adder.sv | 118 +++++++++++
 tb/tb_pipelined_carry_adder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_adder.sv
// Pipelined N-bit add/subtract built from STAGES ripple chunks. The chunk carry is
// registered between stages. The valid/ready handshake freezes the whole pipe on a stall.
module pipelined_carry_adder #(
   parameter int N      = 32,
   parameter int STAGES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         overflow
);
   localparam int W = N / STAGES;

   logic [N-1:0] b_eff;
   logic         c0;
   logic         advance;

   assign b_eff = sub ? ~b : b;
   assign c0    = sub | cin;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         // Operand bits still waiting above this stage's chunk.
         localparam int HI = N - (gi + 1) * W;

         logic [W-1:0]         a_ch;
         logic [W-1:0]         b_ch;
         logic                 c_in;
         logic                 v_in;
         logic [W:0]           add;
         logic [(gi+1)*W-1:0]  s_d;
         logic [(gi+1)*W-1:0]  s_q;
         logic                 c_q;
         logic                 v_q;

         if (gi == 0) begin : g_first
            assign a_ch = a[W-1:0];
            assign b_ch = b_eff[W-1:0];
            assign c_in = c0;
            assign v_in = in_valid;
            assign s_d  = add[W-1:0];
         end else begin : g_next
            assign a_ch = g_stage[gi-1].g_skew.a_hi_q[W-1:0];
            assign b_ch = g_stage[gi-1].g_skew.b_hi_q[W-1:0];
            assign c_in = g_stage[gi-1].c_q;
            assign v_in = g_stage[gi-1].v_q;
            assign s_d  = {add[W-1:0], g_stage[gi-1].s_q};
         end

         assign add = {1'b0, a_ch} + {1'b0, b_ch} + {{W{1'b0}}, c_in};

         always_ff @(posedge clk) begin
            if (rst) begin
               v_q <= 1'b0;
               c_q <= 1'b0;
               s_q <= '0;
            end else if (advance) begin
               v_q <= v_in;
               c_q <= add[W];
               s_q <= s_d;
            end
         end

         if (gi < STAGES - 1) begin : g_skew
            logic [HI-1:0] a_hi_d;
            logic [HI-1:0] b_hi_d;
            logic [HI-1:0] a_hi_q;
            logic [HI-1:0] b_hi_q;

            if (gi == 0) begin : g_src_in
               assign a_hi_d = a[N-1:W];
               assign b_hi_d = b_eff[N-1:W];
            end else begin : g_src_prev
               assign a_hi_d = g_stage[gi-1].g_skew.a_hi_q[HI+W-1:W];
               assign b_hi_d = g_stage[gi-1].g_skew.b_hi_q[HI+W-1:W];
            end

            always_ff @(posedge clk) begin
               if (advance) begin
                  a_hi_q <= a_hi_d;
                  b_hi_q <= b_hi_d;
               end
            end
         end

         // The last chunk holds the operand MSBs, so signed overflow is resolved here.
         if (gi == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk) begin
               if (rst) begin
                  ovf_q <= 1'b0;
               end else if (advance) begin
                  ovf_q <= (a_ch[W-1] == b_ch[W-1]) && (add[W-1] != a_ch[W-1]);
               end
            end
         end
      end
   endgenerate

   assign out_valid = g_stage[STAGES-1].v_q;
   assign sum       = g_stage[STAGES-1].s_q;
   assign cout      = g_stage[STAGES-1].c_q;
   assign overflow  = g_stage[STAGES-1].g_ovf.ovf_q;

   assign in_ready  = !(out_valid && !out_ready);
   assign advance   = in_ready;
endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Directed and streaming checks of pipelined_carry_adder in three shapes:
// 8-bit/2-stage, 8-bit/1-stage and 32-bit/4-stage.
module tb_pipelined_carry_adder;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       iv8, ir8, cin8, sub8, ov8, or8, co8, of8;
   logic [7:0] a8, b8, s8;
   logic       iv1, ir1, cin1, sub1, ov1, or1, co1, of1;
   logic [7:0] a1, b1, s1;
   logic        iv32, ir32, cin32, sub32, ov32, or32, co32, of32;
   logic [31:0] a32, b32, s32;

   int vectors     = 0;
   int miscompares = 0;

   pipelined_carry_adder #(.N(8), .STAGES(2)) u_add8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
      .cout(co8), .overflow(of8));

   pipelined_carry_adder #(.N(8), .STAGES(1)) u_add1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
      .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(s1),
      .cout(co1), .overflow(of1));

   pipelined_carry_adder #(.N(32), .STAGES(4)) u_add32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
      .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32),
      .cout(co32), .overflow(of32));

   // Stimulus helpers: offer one beat and wait (bounded) for its result.
   task automatic run8(input logic [7:0] av, bv, input logic cv, sv,
                       output int lat, output logic [9:0] res);
      @(negedge clk);
      a8 = av; b8 = bv; cin8 = cv; sub8 = sv; iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0;
      lat = 1;
      while (!ov8 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      res = {s8, co8, of8};
   endtask

   task automatic run32(input logic [31:0] av, bv, input logic cv, sv,
                        output int lat, output logic [33:0] res);
      @(negedge clk);
      a32 = av; b32 = bv; cin32 = cv; sub32 = sv; iv32 = 1'b1;
      @(negedge clk);
      iv32 = 1'b0;
      lat = 1;
      while (!ov32 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      res = {s32, co32, of32};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; or8 = 1;
      iv1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; or1 = 1;
      iv32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; or32 = 1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if ({ov8, s8, co8, of8, ir8} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset8: got v/s/c/o/rdy=%b/%h/%b/%b/%b want 0/00/0/0/1", ov8, s8, co8, of8, ir8);
      end
      vectors++;
      if ({ov1, s1, co1, of1, ir1} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset1: got v/s/c/o/rdy=%b/%h/%b/%b/%b want 0/00/0/0/1", ov1, s1, co1, of1, ir1);
      end
      vectors++;
      if ({ov32, s32, co32, of32, ir32} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset32: got v/s/c/o/rdy=%b/%h/%b/%b/%b want 0/0/0/0/1", ov32, s32, co32, of32, ir32);
      end
   endtask

   task automatic test_add8();
      int lat;
      logic [9:0] res;
      run8(8'h0F, 8'h01, 1'b0, 1'b0, lat, res);
      vectors++;
      if (lat !== 2) begin
         miscompares++;
         $display("FAIL add8_latency: got %0d want 2", lat);
      end
      vectors++;
      if (res !== {8'h10, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL add8_chunk_carry: got s/c/o=%h/%b/%b want 10/0/0", res[9:2], res[1], res[0]);
      end
      run8(8'hFF, 8'h01, 1'b1, 1'b0, lat, res);
      vectors++;
      if (res !== {8'h01, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL add8_wrap: got s/c/o=%h/%b/%b want 01/1/0", res[9:2], res[1], res[0]);
      end
      run8(8'h7F, 8'h01, 1'b0, 1'b0, lat, res);
      vectors++;
      if (res !== {8'h80, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL add8_overflow: got s/c/o=%h/%b/%b want 80/0/1", res[9:2], res[1], res[0]);
      end
   endtask

   task automatic test_sub8();
      int lat;
      logic [9:0] res;
      // cin=1 here must be ignored by a subtraction.
      run8(8'h05, 8'h07, 1'b1, 1'b1, lat, res);
      vectors++;
      if (res !== {8'hFE, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL sub8_borrow: got s/c/o=%h/%b/%b want FE/0/0", res[9:2], res[1], res[0]);
      end
      run8(8'h80, 8'h01, 1'b0, 1'b1, lat, res);
      vectors++;
      if (res !== {8'h7F, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL sub8_overflow: got s/c/o=%h/%b/%b want 7F/1/1", res[9:2], res[1], res[0]);
      end
   endtask

   task automatic test_stall1();
      @(negedge clk);
      or1 = 1'b0;
      a1 = 8'h3C; b1 = 8'h44; cin1 = 1'b0; sub1 = 1'b0; iv1 = 1'b1;
      @(negedge clk);
      // A second beat is offered while the first sits stalled at the output.
      a1 = 8'h01; b1 = 8'h02;
      vectors++;
      if ({ov1, s1, co1, of1} !== {1'b1, 8'h80, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL stage1_result: got v/s/c/o=%b/%h/%b/%b want 1/80/0/1", ov1, s1, co1, of1);
      end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if ({ir1, ov1, s1, of1} !== {1'b0, 1'b1, 8'h80, 1'b1}) begin
            miscompares++;
            $display("FAIL stage1_stall%0d: got rdy/v/s/o=%b/%b/%h/%b want 0/1/80/1", i, ir1, ov1, s1, of1);
         end
         @(negedge clk);
      end
      or1 = 1'b1;
      #1;
      vectors++;
      if (ir1 !== 1'b1) begin
         miscompares++;
         $display("FAIL stage1_release_ready: got %b want 1", ir1);
      end
      @(negedge clk);
      iv1 = 1'b0;
      vectors++;
      if ({ov1, s1, co1, of1} !== {1'b1, 8'h03, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL stage1_simultaneous: got v/s/c/o=%b/%h/%b/%b want 1/03/0/0", ov1, s1, co1, of1);
      end
      @(negedge clk);
      vectors++;
      if (ov1 !== 1'b0) begin
         miscompares++;
         $display("FAIL stage1_drain: got out_valid=%b want 0", ov1);
      end
   endtask

   typedef struct {
      logic [31:0] s;
      logic        co;
      logic        of;
      int          c;
      int          st;
      bit          seen;
   } exp_t;

   task automatic test_back_to_back();
      exp_t q[$];
      exp_t e;
      int cyc = 0, stalls = 0, sent = 0, consumed = 0, lat;
      bit have = 0, exp_ir;
      logic [31:0] be;
      logic [32:0] wide;
      while (consumed < 64 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (ov32) begin
            if (q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL stream_extra_beat: got sum=%h with nothing outstanding", s32);
            end else begin
               if (!q[0].seen) begin
                  lat = cyc - q[0].c - (stalls - q[0].st);
                  vectors++;
                  if (lat !== 4) begin
                     miscompares++;
                     $display("FAIL stream_latency: got %0d want 4", lat);
                  end
                  q[0].seen = 1;
               end
               vectors++;
               if ({s32, co32, of32} !== {q[0].s, q[0].co, q[0].of}) begin
                  miscompares++;
                  $display("FAIL stream_result: got s/c/o=%h/%b/%b want %h/%b/%b",
                           s32, co32, of32, q[0].s, q[0].co, q[0].of);
               end
            end
         end
         or32 = ($urandom_range(0, 9) >= 3);
         if (!have && sent < 64 && $urandom_range(0, 3) != 0) begin
            a32 = $urandom; b32 = $urandom;
            cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
            have = 1;
            sent++;
         end
         iv32 = have;
         #1;
         exp_ir = !(ov32 && !or32);
         vectors++;
         if (ir32 !== exp_ir) begin
            miscompares++;
            $display("FAIL stream_in_ready: got %b want %b", ir32, exp_ir);
         end
         if (ov32 && !or32) stalls++;
         if (ov32 && or32 && q.size() > 0) begin
            void'(q.pop_front());
            consumed++;
         end
         if (have && exp_ir) begin
            be   = sub32 ? ~b32 : b32;
            wide = {1'b0, a32} + {1'b0, be} + {32'h0, (sub32 | cin32)};
            e.s  = wide[31:0];
            e.co = wide[32];
            e.of = (a32[31] == be[31]) && (wide[31] != a32[31]);
            e.c  = cyc;
            e.st = stalls;
            e.seen = 0;
            q.push_back(e);
            have = 0;
         end
      end
      iv32 = 1'b0;
      or32 = 1'b1;
      vectors++;
      if (consumed !== 64 || q.size() !== 0) begin
         miscompares++;
         $display("FAIL stream_count: got %0d consumed, %0d outstanding; want 64, 0", consumed, q.size());
      end
   endtask

   task automatic test_reset_midflight();
      int lat;
      logic [33:0] res;
      bit seen = 0;
      @(negedge clk);
      or32 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a32 = 32'h1000 + i; b32 = 32'h1; cin32 = 1'b0; sub32 = 1'b0; iv32 = 1'b1;
         @(negedge clk);
      end
      iv32 = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if ({ov32, ir32} !== 2'b01) begin
         miscompares++;
         $display("FAIL midreset_state: got out_valid/in_ready=%b/%b want 0/1", ov32, ir32);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ov32) seen = 1;
      end
      vectors++;
      if (seen) begin
         miscompares++;
         $display("FAIL midreset_flush: got a discarded beat at the output, want none");
      end
      run32(32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, lat, res);
      vectors++;
      if (lat !== 4) begin
         miscompares++;
         $display("FAIL midreset_latency: got %0d want 4", lat);
      end
      vectors++;
      if (res !== {32'h0, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL midreset_fresh: got s/c/o=%h/%b/%b want 0/1/0", res[33:2], res[1], res[0]);
      end
   endtask

   initial begin
      test_reset();
      test_add8();
      test_sub8();
      test_stall1();
      test_back_to_back();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
